// File: rtl/bist_signature_checker_if.sv
// -----------------------------------------------------------------------------
// bist_signature_checker_if
// Bundles the session handshake and the response/result buses of the BIST
// signature checker.
//   start        : single-cycle session request (master -> checker)
//   resp_data    : 74-bit CUT response word compacted while running
//   abort        : session abort request (only with BIST_ABORT_EN defined)
//   tpg_en       : pattern generator advance enable (checker -> master)
//   busy / done  : session in progress / session finished
//   pass         : signature matched the golden value (valid while done)
//   pattern_cnt  : responses compacted in the current session
//   signature    : live MISR contents
// Modports: master drives the requests, slave is the checker itself.
// -----------------------------------------------------------------------------
interface bist_signature_checker_if;
  logic        start;
  logic [73:0] resp_data;
`ifdef BIST_ABORT_EN
  logic        abort;
`endif
  logic        tpg_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  pattern_cnt;
  logic [73:0] signature;

`ifdef BIST_ABORT_EN
  modport master (output start, resp_data, abort,
                  input  tpg_en, busy, done, pass, pattern_cnt, signature);
  modport slave  (input  start, resp_data, abort,
                  output tpg_en, busy, done, pass, pattern_cnt, signature);
`else
  modport master (output start, resp_data,
                  input  tpg_en, busy, done, pass, pattern_cnt, signature);
  modport slave  (input  start, resp_data,
                  output tpg_en, busy, done, pass, pattern_cnt, signature);
`endif
endinterface

// File: rtl/bist_signature_checker.sv
// -----------------------------------------------------------------------------
// bist_signature_checker
// Compacts N_PATTERNS CUT response words into a 74-bit MISR and compares the
// final signature with GOLDEN.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : bist_signature_checker_if.slave (start, resp_data, [abort],
//           tpg_en, busy, done, pass, pattern_cnt, signature)
// Optional feature: define BIST_ABORT_EN to honour bus.abort, which ends a
// running or comparing session in DONE with pass=0 and the count frozen.
// -----------------------------------------------------------------------------
module bist_signature_checker #(
  parameter int unsigned N_PATTERNS = 255,
  parameter logic [73:0] SEED       = 74'h0,
  parameter logic [73:0] POLY       = 74'h49,
  parameter logic [73:0] GOLDEN     = 74'h1347fb692ca37a6c70c
) (
  input  logic                     clk,
  input  logic                     reset,
  bist_signature_checker_if.slave  bus
);

  localparam logic [7:0] CNT_MAX  = 8'(N_PATTERNS);
  localparam logic [7:0] CNT_LAST = 8'(N_PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

  state_t      state_q, state_d;
  logic [73:0] sig_q;
  logic [7:0]  cnt_q;
  logic        pass_q;
  logic        load, compact, capture;
  logic        tpg_en_c, busy_c, done_c;
  logic        abort_req;

  function automatic logic [73:0] misr_step(input logic [73:0] s,
                                            input logic [73:0] d);
    return {s[72:0], 1'b0} ^ (s[73] ? POLY : 74'h0) ^ d;
  endfunction

  // Count never wraps: it parks at N_PATTERNS.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 8'd1;
  endfunction

`ifdef BIST_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tpg_en_c = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    load     = 1'b0;
    compact  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        tpg_en_c = 1'b1;
        busy_c   = 1'b1;
        // Abort wins over the final compaction; the count stays where it is.
        if (abort_req) begin
          state_d = DONE;
        end else begin
          compact = 1'b1;
          if (cnt_q == CNT_LAST) state_d = COMPARE;
        end
      end
      COMPARE: begin
        busy_c  = 1'b1;
        state_d = DONE;
        if (!abort_req) capture = 1'b1;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pass is cleared on session load so an aborted session reports 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q  <= 74'h0;
      cnt_q  <= 8'h0;
      pass_q <= 1'b0;
    end else if (load) begin
      sig_q  <= SEED;
      cnt_q  <= 8'h0;
      pass_q <= 1'b0;
    end else if (compact) begin
      sig_q  <= misr_step(sig_q, bus.resp_data);
      cnt_q  <= sat_inc(cnt_q);
    end else if (capture) begin
      pass_q <= (sig_q == GOLDEN);
    end
  end

  assign bus.tpg_en      = tpg_en_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.pass        = pass_q;
  assign bus.pattern_cnt = cnt_q;
  assign bus.signature   = sig_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// -----------------------------------------------------------------------------
// tb_bist_signature_checker
// Three checker instances (255 patterns / default golden, 4 patterns / golden
// zero, 1 pattern / default golden) share one stimulus stream. A session-level
// reference model predicts every output of every instance each cycle.
// -----------------------------------------------------------------------------
module tb_bist_signature_checker;

  localparam int          NI       = 3;
  localparam logic [73:0] DEF_GOLD = 74'h1347fb692ca37a6c70c;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [73:0] resp;
`ifdef BIST_ABORT_EN
  logic        abort_v;
`endif

  logic        o_tpg  [NI];
  logic        o_busy [NI];
  logic        o_done [NI];
  logic        o_pass [NI];
  logic [7:0]  o_cnt  [NI];
  logic [73:0] o_sig  [NI];

  bist_signature_checker_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bus[g].start     = start;
    assign bus[g].resp_data = resp;
`ifdef BIST_ABORT_EN
    assign bus[g].abort     = abort_v;
`endif
    assign o_tpg[g]  = bus[g].tpg_en;
    assign o_busy[g] = bus[g].busy;
    assign o_done[g] = bus[g].done;
    assign o_pass[g] = bus[g].pass;
    assign o_cnt[g]  = bus[g].pattern_cnt;
    assign o_sig[g]  = bus[g].signature;

    bist_signature_checker #(
      .N_PATTERNS ((g == 0) ? 255 : ((g == 1) ? 4 : 1)),
      .GOLDEN     ((g == 1) ? 74'h0 : DEF_GOLD)
    ) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one session per instance, tracked by the number of edges
  // since the start edge (k) and the signature folded from sampled words.
  int          np     [NI];
  logic [73:0] gold   [NI];
  bit          m_act  [NI];
  int          m_k    [NI];
  bit          m_ab   [NI];
  logic [73:0] m_sig  [NI];
  bit          m_pass [NI];

  task automatic check(input string tag, input logic [73:0] obs,
                       input logic [73:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [73:0] misr(input logic [73:0] s,
                                       input logic [73:0] d);
    logic [73:0] r;
    r = s << 1;
    if (s[73]) r = r ^ 74'h49;
    return r ^ d;
  endfunction

  function automatic logic [73:0] rnd74();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[73:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_act[i]  = 1'b0;
      m_k[i]    = 0;
      m_ab[i]   = 1'b0;
      m_sig[i]  = 74'h0;
      m_pass[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit run, cmp, dn;
    if (!rst_n) return;
    for (int i = 0; i < NI; i++) begin
      run = m_act[i] && !m_ab[i] && (m_k[i] < np[i]);
      cmp = m_act[i] && !m_ab[i] && (m_k[i] == np[i]);
      dn  = m_act[i] && (m_ab[i] || (m_k[i] > np[i]));
      if ((!m_act[i] || dn) && start) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 0;
        m_ab[i]   = 1'b0;
        m_sig[i]  = 74'h0;
        m_pass[i] = 1'b0;
      end
`ifdef BIST_ABORT_EN
      else if ((run || cmp) && abort_v) begin
        m_ab[i] = 1'b1;
      end
`endif
      else if (run) begin
        m_sig[i] = misr(m_sig[i], resp);
        m_k[i]++;
      end else if (cmp) begin
        m_pass[i] = (m_sig[i] == gold[i]);
        m_k[i]++;
      end
    end
  endtask

  task automatic check_outputs();
    bit run, cmp, dn;
    int cnt;
    for (int i = 0; i < NI; i++) begin
      run = m_act[i] && !m_ab[i] && (m_k[i] < np[i]);
      cmp = m_act[i] && !m_ab[i] && (m_k[i] == np[i]);
      dn  = m_act[i] && (m_ab[i] || (m_k[i] > np[i]));
      cnt = (m_k[i] < np[i]) ? m_k[i] : np[i];
      check($sformatf("u%0d.tpg_en", i), 74'(o_tpg[i]), 74'(run));
      check($sformatf("u%0d.busy", i), 74'(o_busy[i]), 74'(run || cmp));
      check($sformatf("u%0d.done", i), 74'(o_done[i]), 74'(dn));
      check($sformatf("u%0d.pass", i), 74'(o_pass[i]), 74'(dn && m_pass[i]));
      check($sformatf("u%0d.pattern_cnt", i), 74'(o_cnt[i]), 74'(cnt));
      check($sformatf("u%0d.signature", i), o_sig[i], m_sig[i]);
    end
  endtask

  task automatic cycle(input bit st, input logic [73:0] d);
    @(negedge clk);
    check_outputs();
    start = st;
    resp  = d;
`ifdef BIST_ABORT_EN
    abort_v = ($urandom_range(0, 40) == 0);
`endif
    @(posedge clk);
    model_step();
  endtask

  // Assert reset mid-cycle, check the immediate clear, hold it with random
  // inputs, then release and request a session on the very first edge.
  task automatic async_reset(input int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    repeat (hold) cycle(1'($urandom_range(0, 1)), rnd74());
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    start = 1'b1;
    resp  = rnd74();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    np[0] = 255; np[1] = 4; np[2] = 1;
    gold[0] = DEF_GOLD; gold[1] = 74'h0; gold[2] = DEF_GOLD;
    rst_n = 1'b0;
    start = 1'b0;
    resp  = 74'h0;
`ifdef BIST_ABORT_EN
    abort_v = 1'b0;
`endif
    model_reset();

    // Held in reset with random inputs: everything stays zero.
    repeat (4) cycle(1'($urandom_range(0, 1)), rnd74());
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    start = 1'b1;
    resp  = rnd74();
    @(posedge clk);
    model_step();

    // All-zero responses: the 4-pattern instance matches golden zero.
    repeat (300) cycle(1'b0, 74'h0);

    // Single-pattern instance: response equal to golden, then response 1.
    cycle(1'b1, rnd74());
    cycle(1'b0, DEF_GOLD);
    repeat (3) cycle(1'b0, rnd74());
    cycle(1'b1, rnd74());
    cycle(1'b0, 74'h1);
    repeat (300) cycle(1'b0, rnd74());

    // Restart request mid-session, then reset mid-session.
    cycle(1'b1, rnd74());
    repeat (2) cycle(1'b0, rnd74());
    cycle(1'b1, rnd74());
    cycle(1'b0, rnd74());
    async_reset(3);
    repeat (300) cycle(1'b0, rnd74());

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) async_reset($urandom_range(0, 3));
      else cycle(($urandom_range(0, 15) == 0), rnd74());
    end
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
